mem_arbiter: RTL and testbench

- Shares one external memory port between the core's instruction-fetch requester and data load/store requester.
- The memory port has variable latency with an ack; this block turns it into two independent request/ready channels.
- Also produces the pipeline stall.
- Sits between the cpu top level and the unified memory; round-robin grant, one outstanding transaction, watchdog timeout.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_watchdog.sv | 28 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and grant selection for the memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ST_BUSY_I = 2'd1;
   localparam logic [ST_W-1:0] ST_BUSY_D = 2'd2;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Round-robin pick: with both eligible, favour the one not granted last.
   function automatic logic rr_pick(input logic i_el, input logic d_el, input logic last);
      if (i_el && d_el) begin
         return (last == GNT_I) ? GNT_D : GNT_I;
      end else if (d_el) begin
         return GNT_D;
      end else begin
         return GNT_I;
      end
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory channels of the arbiter, plus err/stall.
interface mem_arbiter_if #(
   parameter int unsigned XLEN = 64
);
   logic            i_req;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_rdata;
   logic            i_ready;
   logic            d_req;
   logic            d_we;
   logic [XLEN-1:0] d_addr;
   logic [XLEN-1:0] d_wdata;
   logic [XLEN-1:0] d_rdata;
   logic            d_ready;
   logic            m_req;
   logic            m_we;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic [XLEN-1:0] m_rdata;
   logic            m_ack;
   logic            err;
   logic            stall;

   // Arbiter side: serves both requesters and drives the memory port.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_ready, d_rdata, d_ready,
      output m_req, m_we, m_addr, m_wdata, err, stall
   );

   // Environment side: the core requesters and the memory.
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_ready, d_rdata, d_ready,
      input  m_req, m_we, m_addr, m_wdata, err, stall
   );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Busy-cycle counter; expired_c flags the last cycle before an abort.
module mem_arbiter_watchdog #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   logic [CW-1:0] count;

   // Clear on grant, count while a transaction is waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expired_c = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 8
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);

   logic [ST_W-1:0] state, state_nx;
   logic            last, last_nx;
   logic            gnt;
   logic            i_el, d_el;
   logic            wd_clr, wd_en, wd_expired_c;

   logic            m_req_nx, m_we_nx;
   logic [XLEN-1:0] m_addr_nx, m_wdata_nx;
   logic            i_ready_nx, d_ready_nx, err_nx;
   logic [XLEN-1:0] i_rdata_nx, d_rdata_nx;

   // A requester sitting in its ready cycle is not eligible for a new grant.
   assign i_el = bus.i_req & ~bus.i_ready;
   assign d_el = bus.d_req & ~bus.d_ready;

   // Core must wait while any request is outstanding and not yet completed.
   assign bus.stall = (bus.i_req & ~bus.i_ready) | (bus.d_req & ~bus.d_ready);

   mem_arbiter_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr       (wd_clr),
      .en        (wd_en),
      .expired_c (wd_expired_c)
   );

   // Next-state and next-output decode.
   always_comb begin
      state_nx   = state;
      last_nx    = last;
      gnt        = GNT_I;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
      m_req_nx   = bus.m_req;
      m_we_nx    = bus.m_we;
      m_addr_nx  = bus.m_addr;
      m_wdata_nx = bus.m_wdata;
      i_ready_nx = 1'b0;
      d_ready_nx = 1'b0;
      err_nx     = 1'b0;
      i_rdata_nx = bus.i_rdata;
      d_rdata_nx = bus.d_rdata;

      case (state)
         ST_IDLE: begin
            wd_clr = 1'b1;
            if (i_el || d_el) begin
               gnt      = rr_pick(i_el, d_el, last);
               last_nx  = gnt;
               m_req_nx = 1'b1;
               if (gnt == GNT_D) begin
                  m_we_nx    = bus.d_we;
                  m_addr_nx  = bus.d_addr;
                  m_wdata_nx = bus.d_wdata;
                  state_nx   = ST_BUSY_D;
               end else begin
                  m_we_nx    = 1'b0;
                  m_addr_nx  = bus.i_addr;
                  m_wdata_nx = '0;
                  state_nx   = ST_BUSY_I;
               end
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            wd_en = 1'b1;
            if (bus.m_ack || wd_expired_c) begin
               m_req_nx = 1'b0;
               err_nx   = ~bus.m_ack;
               state_nx = ST_IDLE;
               if (state == ST_BUSY_I) begin
                  i_ready_nx = 1'b1;
                  i_rdata_nx = bus.m_ack ? bus.m_rdata : '0;
               end else begin
                  d_ready_nx = 1'b1;
                  d_rdata_nx = (bus.m_ack && !bus.m_we) ? bus.m_rdata : '0;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         last        <= GNT_I;
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.i_ready <= 1'b0;
         bus.d_ready <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_rdata <= '0;
         bus.err     <= 1'b0;
      end else begin
         state       <= state_nx;
         last        <= last_nx;
         bus.m_req   <= m_req_nx;
         bus.m_we    <= m_we_nx;
         bus.m_addr  <= m_addr_nx;
         bus.m_wdata <= m_wdata_nx;
         bus.i_ready <= i_ready_nx;
         bus.d_ready <= d_ready_nx;
         bus.i_rdata <= i_rdata_nx;
         bus.d_rdata <= d_rdata_nx;
         bus.err     <= err_nx;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=4 so aborts are quick to reach).
module tb_mem_arbiter;

   localparam int unsigned XLEN = 64;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mem_arbiter_if #(.XLEN(XLEN)) bus ();

   mem_arbiter #(
      .XLEN    (XLEN),
      .TIMEOUT (4),
      .CW      (8)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {m_req, i_ready, d_ready, err, stall}
   function automatic logic [4:0] flags();
      return {bus.m_req, bus.i_ready, bus.d_ready, bus.err, bus.stall};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.m_ack = 1'b0; bus.m_rdata = '0;
      tick(); tick();
      n_cmp++;
      if (flags() !== 5'b00000) begin n_err++; $display("FAIL reset_flags: got %b expected %b", flags(), 5'b00000); end
      n_cmp++;
      if ({bus.m_we, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin
         n_err++; $display("FAIL reset_data: got m_we=%b m_addr=%0h m_wdata=%0h i_rdata=%0h d_rdata=%0h expected all 0",
                           bus.m_we, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_ack();
      bus.m_ack = 1'b1; bus.m_rdata = 64'hFF;
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b00000) begin n_err++; $display("FAIL idle_ack_flags: got %b expected %b", flags(), 5'b00000); end
      n_cmp++;
      if (bus.i_rdata !== 64'h0) begin n_err++; $display("FAIL idle_ack_rdata: got %0h expected 0", bus.i_rdata); end
      tick();
   endtask

   task automatic test_fetch();
      logic [4:0] exp_f [1:3];
      bus.i_req = 1'b1; bus.i_addr = 64'h1000;
      #1;
      n_cmp++;
      if (flags() !== 5'b00001) begin n_err++; $display("FAIL fetch_c0: got %b expected %b", flags(), 5'b00001); end
      tick();
      exp_f[1] = 5'b10001; exp_f[2] = 5'b10001; exp_f[3] = 5'b10001;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin bus.m_ack = 1'b1; bus.m_rdata = 64'h13; end
         #1;
         n_cmp++;
         if (flags() !== exp_f[c] || bus.m_addr !== 64'h1000 || bus.m_we !== 1'b0) begin
            n_err++; $display("FAIL fetch_c%0d: got flags=%b m_addr=%0h m_we=%b expected flags=%b m_addr=1000 m_we=0",
                              c, flags(), bus.m_addr, bus.m_we, exp_f[c]);
         end
         tick();
      end
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b01000 || bus.i_rdata !== 64'h13) begin
         n_err++; $display("FAIL fetch_c4: got flags=%b i_rdata=%0h expected flags=01000 i_rdata=13", flags(), bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
      n_cmp++;
      if (flags() !== 5'b00000 || bus.i_rdata !== 64'h13) begin
         n_err++; $display("FAIL fetch_c5: got flags=%b i_rdata=%0h expected flags=00000 i_rdata=13", flags(), bus.i_rdata);
      end
   endtask

   task automatic test_store();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h2008; bus.d_wdata = 64'hDEADBEEF;
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h5555;
      #1;
      n_cmp++;
      if (flags() !== 5'b10001 || bus.m_we !== 1'b1 || bus.m_addr !== 64'h2008 || bus.m_wdata !== 64'hDEADBEEF) begin
         n_err++; $display("FAIL store_c1: got flags=%b m_we=%b m_addr=%0h m_wdata=%0h expected flags=10001 m_we=1 m_addr=2008 m_wdata=deadbeef",
                           flags(), bus.m_we, bus.m_addr, bus.m_wdata);
      end
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b00100 || bus.d_rdata !== 64'h0) begin
         n_err++; $display("FAIL store_c2: got flags=%b d_rdata=%0h expected flags=00100 d_rdata=0", flags(), bus.d_rdata);
      end
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      tick();
      n_cmp++;
      if (flags() !== 5'b00000) begin n_err++; $display("FAIL store_c3: got %b expected %b", flags(), 5'b00000); end
   endtask

   // Fresh reset leaves last=I, so each round grants data first, then fetch.
   task automatic test_round_robin();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int r = 0; r < 2; r++) begin
         bus.i_req = 1'b1; bus.i_addr = 64'h4000;
         bus.d_req = 1'b1; bus.d_addr = 64'h3000; bus.d_we = 1'b0;
         tick();
         bus.m_ack = 1'b1; bus.m_rdata = 64'hA0 + 64'(r);
         #1;
         n_cmp++;
         if (flags() !== 5'b10001 || bus.m_addr !== 64'h3000) begin
            n_err++; $display("FAIL rr%0d_first: got flags=%b m_addr=%0h expected flags=10001 m_addr=3000", r, flags(), bus.m_addr);
         end
         tick();
         bus.m_ack = 1'b0;
         #1;
         n_cmp++;
         if (flags() !== 5'b00101 || bus.d_rdata !== 64'hA0 + 64'(r)) begin
            n_err++; $display("FAIL rr%0d_dready: got flags=%b d_rdata=%0h expected flags=00101 d_rdata=%0h",
                              r, flags(), bus.d_rdata, 64'hA0 + 64'(r));
         end
         bus.d_req = 1'b0;
         tick();
         bus.m_ack = 1'b1; bus.m_rdata = 64'hB0 + 64'(r);
         #1;
         n_cmp++;
         if (flags() !== 5'b10001 || bus.m_addr !== 64'h4000 || bus.m_we !== 1'b0) begin
            n_err++; $display("FAIL rr%0d_second: got flags=%b m_addr=%0h m_we=%b expected flags=10001 m_addr=4000 m_we=0",
                              r, flags(), bus.m_addr, bus.m_we);
         end
         tick();
         bus.m_ack = 1'b0;
         #1;
         n_cmp++;
         if (flags() !== 5'b01000 || bus.i_rdata !== 64'hB0 + 64'(r)) begin
            n_err++; $display("FAIL rr%0d_iready: got flags=%b i_rdata=%0h expected flags=01000 i_rdata=%0h",
                              r, flags(), bus.i_rdata, 64'hB0 + 64'(r));
         end
         bus.i_req = 1'b0;
         tick();
      end
   endtask

   // Fetch holds req through its ready cycles; data arrives during one of them.
   task automatic test_back_to_back();
      bus.i_req = 1'b1; bus.i_addr = 64'h6000;
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h61;
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b01000 || bus.i_rdata !== 64'h61) begin
         n_err++; $display("FAIL b2b_ready1: got flags=%b i_rdata=%0h expected flags=01000 i_rdata=61", flags(), bus.i_rdata);
      end
      tick();
      n_cmp++;
      if (flags() !== 5'b00001) begin n_err++; $display("FAIL b2b_no_regrant: got %b expected %b", flags(), 5'b00001); end
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h62;
      #1;
      n_cmp++;
      if (flags() !== 5'b10001 || bus.m_addr !== 64'h6000) begin
         n_err++; $display("FAIL b2b_regrant: got flags=%b m_addr=%0h expected flags=10001 m_addr=6000", flags(), bus.m_addr);
      end
      tick();
      bus.m_ack = 1'b0;
      bus.d_req = 1'b1; bus.d_addr = 64'h5000; bus.d_we = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b01001 || bus.i_rdata !== 64'h62) begin
         n_err++; $display("FAIL b2b_ready2: got flags=%b i_rdata=%0h expected flags=01001 i_rdata=62", flags(), bus.i_rdata);
      end
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h63;
      #1;
      n_cmp++;
      if (flags() !== 5'b10001 || bus.m_addr !== 64'h5000 || bus.m_we !== 1'b0) begin
         n_err++; $display("FAIL b2b_dgrant: got flags=%b m_addr=%0h m_we=%b expected flags=10001 m_addr=5000 m_we=0",
                           flags(), bus.m_addr, bus.m_we);
      end
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b00101 || bus.d_rdata !== 64'h63) begin
         n_err++; $display("FAIL b2b_dready: got flags=%b d_rdata=%0h expected flags=00101 d_rdata=63", flags(), bus.d_rdata);
      end
      bus.d_req = 1'b0;
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h64;
      #1;
      n_cmp++;
      if (flags() !== 5'b10001 || bus.m_addr !== 64'h6000) begin
         n_err++; $display("FAIL b2b_igrant: got flags=%b m_addr=%0h expected flags=10001 m_addr=6000", flags(), bus.m_addr);
      end
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b01000 || bus.i_rdata !== 64'h64) begin
         n_err++; $display("FAIL b2b_iready: got flags=%b i_rdata=%0h expected flags=01000 i_rdata=64", flags(), bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      bus.i_req = 1'b1; bus.i_addr = 64'h7000;
      tick();
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_cmp++;
         if (flags() !== 5'b10001) begin n_err++; $display("FAIL timeout_c%0d: got %b expected %b", c, flags(), 5'b10001); end
         tick();
      end
      #1;
      n_cmp++;
      if (flags() !== 5'b01010 || bus.i_rdata !== 64'h0) begin
         n_err++; $display("FAIL timeout_abort: got flags=%b i_rdata=%0h expected flags=01010 i_rdata=0", flags(), bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
      n_cmp++;
      if (flags() !== 5'b00000) begin n_err++; $display("FAIL timeout_idle: got %b expected %b", flags(), 5'b00000); end
   endtask

   task automatic test_reset_mid();
      bus.d_req = 1'b1; bus.d_addr = 64'h8000; bus.d_we = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (flags() !== 5'b00001) begin n_err++; $display("FAIL rstmid_async: got %b expected %b", flags(), 5'b00001); end
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b00001) begin n_err++; $display("FAIL rstmid_release: got %b expected %b", flags(), 5'b00001); end
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 64'h81;
      #1;
      n_cmp++;
      if (flags() !== 5'b10001 || bus.m_addr !== 64'h8000) begin
         n_err++; $display("FAIL rstmid_regrant: got flags=%b m_addr=%0h expected flags=10001 m_addr=8000", flags(), bus.m_addr);
      end
      tick();
      bus.m_ack = 1'b0;
      #1;
      n_cmp++;
      if (flags() !== 5'b00100 || bus.d_rdata !== 64'h81) begin
         n_err++; $display("FAIL rstmid_dready: got flags=%b d_rdata=%0h expected flags=00100 d_rdata=81", flags(), bus.d_rdata);
      end
      bus.d_req = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_idle_ack();
      test_fetch();
      test_store();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got no finish expected finish before 100000");
      $fatal(1, "simulation time limit");
   end

endmodule
